// File: rtl/dmem_sized.sv
// Byte/half/word addressable data memory with RV32I load extension and a
// READ_LATENCY-deep read pipeline. Rejected requests raise a one-cycle misaligned pulse.
module dmem_sized #(
   parameter int ADDR_SIZE    = 10,
   parameter int DATA_SIZE    = 32,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = ""
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [ADDR_SIZE-1:0] daddr,
   input  logic                 mem_write,
   input  logic                 mem_read,
   input  logic [2:0]           funct3,
   input  logic [31:0]          ddata_w,
   output logic [31:0]          ddata_r,
   output logic                 ddata_valid,
   output logic                 misaligned
);
   localparam int DEPTH = 2 ** (ADDR_SIZE - 2);

   generate
      if (DATA_SIZE != 32) begin : g_bad_data_size
         $fatal(1, "dmem_sized: DATA_SIZE must be 32");
      end
      if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
         $fatal(1, "dmem_sized: READ_LATENCY must be 1..4");
      end
   endgenerate

   logic [31:0] mem [DEPTH];

   // Size/alignment legality; anything not B/H/W/BU/HU is rejected.
   function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'b000, 3'b100: access_ok = 1'b1;
         3'b001, 3'b101: access_ok = (off[0] == 1'b0);
         3'b010:         access_ok = (off == 2'b00);
         default:        access_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   lane_mask = 4'b0001 << off;
         2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Replicating the store data lets each lane take its bits in place.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   store_lanes = {4{wd[7:0]}};
         2'b01:   store_lanes = {2{wd[15:0]}};
         default: store_lanes = wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {off, 3'b000};
      b       = shifted[7:0];
      h       = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_extend = {{24{b[7]}}, b};
         3'b100:  load_extend = {24'h000000, b};
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b101:  load_extend = {16'h0000, h};
         3'b010:  load_extend = word;
         default: load_extend = 32'h00000000;
      endcase
   endfunction

   logic [ADDR_SIZE-3:0]    widx_s;
   logic [1:0]              off_s;
   logic                    ok_s;
   logic                    wr_en_s;
   logic                    rd_en_s;
   logic [3:0]              be_s;
   logic [31:0]             wdata_s;
   logic                    misaligned_d, misaligned_q;
   logic [READ_LATENCY-1:0] vld_d, vld_q;
   logic [31:0]             data_d [READ_LATENCY];
   logic [31:0]             data_q [READ_LATENCY];

   assign widx_s = daddr[ADDR_SIZE-1:2];
   assign off_s  = daddr[1:0];

   // Request decode and next state of the read pipeline.
   always_comb begin
      ok_s         = access_ok(funct3, off_s) & ~(mem_write & mem_read);
      wr_en_s      = mem_write & ok_s & RESET_N;
      rd_en_s      = mem_read & ok_s;
      be_s         = lane_mask(funct3, off_s);
      wdata_s      = store_lanes(funct3, ddata_w);
      misaligned_d = (mem_write | mem_read) & ~ok_s;
      vld_d        = '0;
      vld_d[0]     = rd_en_s;
      for (int i = 0; i < READ_LATENCY; i++) begin
         data_d[i] = 32'h00000000;
      end
      if (rd_en_s) begin
         data_d[0] = load_extend(funct3, off_s, mem[widx_s]);
      end else begin
         data_d[0] = 32'h00000000;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i]  = vld_q[i-1];
         data_d[i] = data_q[i-1];
      end
   end

   // Array write; deliberately outside reset so contents survive RESET_N.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline and misaligned flag; reset discards loads in flight.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vld_q        <= '0;
         misaligned_q <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_q[i] <= 32'h00000000;
         end
      end else begin
         vld_q        <= vld_d;
         misaligned_q <= misaligned_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign ddata_valid = vld_q[READ_LATENCY-1];
   assign ddata_r     = data_q[READ_LATENCY-1];
   assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench: latency-1 and latency-3 instances share stimulus and are
// compared against a byte-addressed reference memory.
module tb_dmem_sized;
   logic        CLK;
   logic        RESET_N;
   logic [9:0]  daddr;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  funct3;
   logic [31:0] ddata_w;
   logic [31:0] r1, r3;
   logic        v1, v3, m1, m3;

   dmem_sized #(.ADDR_SIZE(10), .DATA_SIZE(32), .READ_LATENCY(1), .INIT_FILE("")) u_lat1 (
      .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .mem_write(mem_write),
      .mem_read(mem_read), .funct3(funct3), .ddata_w(ddata_w),
      .ddata_r(r1), .ddata_valid(v1), .misaligned(m1));

   dmem_sized #(.ADDR_SIZE(10), .DATA_SIZE(32), .READ_LATENCY(3), .INIT_FILE("")) u_lat3 (
      .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .mem_write(mem_write),
      .mem_read(mem_read), .funct3(funct3), .ddata_w(ddata_w),
      .ddata_r(r3), .ddata_valid(v3), .misaligned(m3));

   always #5 CLK = ~CLK;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   logic [7:0]  mb [1024];
   logic        s1_v [16];
   logic [31:0] s1_d [16];
   logic        s3_v [16];
   logic [31:0] s3_d [16];
   logic        exp_mis;
   int          cyc;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
      case (f3)
         F_B:     model_load = {{24{mb[a][7]}}, mb[a]};
         F_BU:    model_load = {24'h000000, mb[a]};
         F_H:     model_load = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
         F_HU:    model_load = {16'h0000, mb[a+1], mb[a]};
         default: model_load = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
      endcase
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < 16; i++) begin
         s1_v[i] = 1'b0; s1_d[i] = 32'h0; s3_v[i] = 1'b0; s3_d[i] = 32'h0;
      end
   endtask

   // Reference behaviour of one accepting edge.
   task automatic model_edge(input logic we, input logic re, input logic [2:0] f3,
                             input logic [9:0] a, input logic [31:0] wd);
      int sz;
      bit legal;
      logic [31:0] v;
      case (f3)
         F_B, F_BU: sz = 1;
         F_H, F_HU: sz = 2;
         F_W:       sz = 4;
         default:   sz = 0;
      endcase
      legal   = (sz != 0) && ((int'(a) % sz) == 0) && !(we && re);
      exp_mis = (we || re) && !legal;
      if (legal && we) begin
         for (int k = 0; k < sz; k++) mb[int'(a) + k] = wd[8*k +: 8];
      end
      if (legal && re) begin
         v = model_load(f3, int'(a));
         s1_v[cyc % 16]       = 1'b1; s1_d[cyc % 16]       = v;
         s3_v[(cyc + 2) % 16] = 1'b1; s3_d[(cyc + 2) % 16] = v;
      end
   endtask

   task automatic check_outputs();
      int idx;
      idx = cyc % 16;
      chk("valid_lat1", v1, s1_v[idx]);
      chk("data_lat1", r1, s1_d[idx]);
      chk("valid_lat3", v3, s3_v[idx]);
      chk("data_lat3", r3, s3_d[idx]);
      chk("misaligned_lat1", m1, exp_mis);
      chk("misaligned_lat3", m3, exp_mis);
      s1_v[idx] = 1'b0; s1_d[idx] = 32'h0; s3_v[idx] = 1'b0; s3_d[idx] = 32'h0;
      cyc++;
   endtask

   // Called at a negedge; drives one request for the coming edge and checks after it.
   task automatic step(input logic we, input logic re, input logic [2:0] f3,
                       input logic [9:0] a, input logic [31:0] wd);
      mem_write = we; mem_read = re; funct3 = f3; daddr = a; ddata_w = wd;
      @(posedge CLK);
      model_edge(we, re, f3, a, wd);
      #1;
      check_outputs();
      @(negedge CLK);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, F_W, 10'h000, 32'h0);
   endtask

   initial begin
      CLK = 1'b0; RESET_N = 1'b0;
      mem_write = 1'b0; mem_read = 1'b0; funct3 = F_W; daddr = 10'h000; ddata_w = 32'h0;
      n_checks = 0; n_errors = 0; cyc = 0; exp_mis = 1'b0;
      clear_sched();

      #1;
      chk("reset_valid1", v1, 1'b0); chk("reset_data1", r1, 32'h0); chk("reset_mis1", m1, 1'b0);
      chk("reset_valid3", v3, 1'b0); chk("reset_data3", r3, 32'h0); chk("reset_mis3", m3, 1'b0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      idle();

      step(1'b1, 1'b0, F_W, 10'h010, 32'hDEADBEEF);
      step(1'b0, 1'b1, F_W, 10'h010, 32'h0);
      chk("lw_deadbeef_valid", v1, 1'b1);
      chk("lw_deadbeef", r1, 32'hDEADBEEF);
      step(1'b1, 1'b0, F_B, 10'h012, 32'h000000AA);
      step(1'b0, 1'b1, F_B, 10'h012, 32'h0);
      chk("lb_aa", r1, 32'hFFFFFFAA);
      step(1'b0, 1'b1, F_BU, 10'h012, 32'h0);
      chk("lbu_aa", r1, 32'h000000AA);
      step(1'b0, 1'b1, F_W, 10'h010, 32'h0);
      chk("lw_merged", r1, 32'hDEAABEEF);

      step(1'b1, 1'b0, F_H, 10'h020, 32'h00008001);
      step(1'b0, 1'b1, F_H, 10'h020, 32'h0);
      chk("lh_8001", r1, 32'hFFFF8001);
      step(1'b0, 1'b1, F_HU, 10'h020, 32'h0);
      chk("lhu_8001", r1, 32'h00008001);
      step(1'b0, 1'b1, F_H, 10'h021, 32'h0);
      chk("lh_odd_mis", m1, 1'b1);
      chk("lh_odd_novalid", v1, 1'b0);

      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, F_W, 10'(4 * i), 32'h11111111 * (i + 1));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, F_W, 10'(4 * i), 32'h0);
      repeat (4) idle();

      step(1'b1, 1'b0, F_W, 10'h030, 32'hCAFEF00D);
      step(1'b1, 1'b1, F_W, 10'h030, 32'h12345678);
      chk("rw_both_mis", m1, 1'b1);
      step(1'b0, 1'b1, F_W, 10'h030, 32'h0);
      chk("rw_both_unchanged", r1, 32'hCAFEF00D);

      step(1'b0, 1'b1, F_W, 10'h010, 32'h0);
      idle();
      #2;
      RESET_N = 1'b0;
      mem_write = 1'b1; funct3 = F_W; daddr = 10'h010; ddata_w = 32'h55555555;
      #1;
      chk("async_clr_valid3", v3, 1'b0); chk("async_clr_data3", r3, 32'h0);
      chk("async_clr_valid1", v1, 1'b0); chk("async_clr_mis1", m1, 1'b0);
      clear_sched();
      exp_mis = 1'b0;
      #14;
      mem_write = 1'b0;
      RESET_N = 1'b1;
      @(negedge CLK);
      repeat (4) idle();
      step(1'b0, 1'b1, F_W, 10'h010, 32'h0);
      chk("post_reset_lw1", r1, 32'hDEAABEEF);
      idle();
      idle();
      chk("post_reset_lw3", r3, 32'hDEAABEEF);

      for (int w = 0; w < 256; w++) step(1'b1, 1'b0, F_W, 10'(4 * w), $urandom);
      for (int n = 0; n < 400; n++) begin
         logic we, re;
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 0);
         step(we, re, 3'($urandom_range(0, 7)), 10'($urandom), $urandom);
      end
      repeat (4) idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
